// File: rtl/cpu_param_pkg.sv
// ============================================================================
// cpu_param_pkg : shared opcode, mode and FSM-state encodings for cpu_core_param
// Rev 1.0
// ============================================================================
`default_nettype none

package cpu_param_pkg;

  localparam int OPC_W  = 4;
  localparam int MODE_W = 2;

  typedef enum logic [OPC_W-1:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_MUL    = 4'd2,
    OP_AND    = 4'd3,
    OP_OR     = 4'd4,
    OP_XOR    = 4'd5,
    OP_NOT_A  = 4'd6,
    OP_SHL    = 4'd7,
    OP_SHR    = 4'd8,
    OP_PASS_A = 4'd9,
    OP_PASS_B = 4'd10
  } op_e;

  typedef enum logic [MODE_W-1:0] {
    MODE_ALU   = 2'd0,
    MODE_STORE = 2'd1,
    MODE_LOAD  = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EXEC  = 3'd1,
    ST_MEMWR = 3'd2,
    ST_MEMRD = 3'd3,
    ST_MEMWB = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

endpackage

`default_nettype wire

// File: rtl/cpu_alu_param.sv
// ============================================================================
// cpu_alu_param : combinational ALU, WIDTH-bit operands, 2*WIDTH-bit result.
// Macro CPU_MUL_EN enables the multiplier; otherwise op 2 is reported invalid.
// Rev 1.0
// ============================================================================
`default_nettype none

module cpu_alu_param
  import cpu_param_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [OPC_W-1:0]   op,
  output logic [2*WIDTH-1:0] result,
  output logic               invalid
);

  logic [2*WIDTH-1:0] a_x;
  logic [2*WIDTH-1:0] b_x;

  assign a_x = {{WIDTH{1'b0}}, a};
  assign b_x = {{WIDTH{1'b0}}, b};

  always_comb begin
    result  = '0;
    invalid = 1'b0;
    case (op)
      OP_ADD:    result = a_x + b_x;
      OP_SUB:    result = a_x - b_x;
`ifdef CPU_MUL_EN
      OP_MUL:    result = a_x * b_x;
`endif
      OP_AND:    result = a_x & b_x;
      OP_OR:     result = a_x | b_x;
      OP_XOR:    result = a_x ^ b_x;
      OP_NOT_A:  result = {{WIDTH{1'b0}}, ~a};
      OP_SHL:    result = a_x << 1;
      OP_SHR:    result = a_x >> 1;
      OP_PASS_A: result = a_x;
      OP_PASS_B: result = b_x;
      // Reserved codes (and MUL when the multiplier is absent) yield 0 + invalid
      default:   invalid = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/cpu_core_param.sv
// ============================================================================
// cpu_core_param : command-driven CPU datapath with ALU, result register and
// on-chip result memory. Optional multiplier via macro CPU_MUL_EN. Rev 1.0
// ============================================================================
`default_nettype none

module cpu_core_param
  import cpu_param_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int N_IN      = 4,
  parameter  int MEM_DEPTH = 256,
  localparam int SEL_W     = ($clog2(N_IN) > 1) ? $clog2(N_IN) : 1,
  localparam int ADDR_W    = $clog2(MEM_DEPTH),
  localparam int CMD_W     = MODE_W + 2*SEL_W + OPC_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  input  logic [CMD_W-1:0]      cmd_in,
  input  logic [N_IN*WIDTH-1:0] din,
  output logic                  cpu_rdy,
  output logic                  done,
  output logic [2*WIDTH-1:0]    out_reg3,
  output logic                  zero,
  output logic                  error
);

  localparam logic [SEL_W:0] N_IN_EXT = (SEL_W+1)'(N_IN);

  logic [MODE_W-1:0] cmd_mode;
  logic [SEL_W-1:0]  cmd_sel_a;
  logic [SEL_W-1:0]  cmd_sel_b;
  logic [OPC_W-1:0]  cmd_op;
  logic [WIDTH-1:0]  chan_a;
  logic [WIDTH-1:0]  chan_b;
  logic              sel_bad;

  state_e             state_q,    state_d;
  logic [OPC_W-1:0]   op_q,       op_d;
  logic [WIDTH-1:0]   op_a_q,     op_a_d;
  logic [WIDTH-1:0]   op_b_q,     op_b_d;
  logic [ADDR_W-1:0]  addr_q,     addr_d;
  logic               sel_bad_q,  sel_bad_d;
  logic [2*WIDTH-1:0] out_reg3_q, out_reg3_d;
  logic               zero_q,     zero_d;
  logic               error_q,    error_d;
  logic               done_q,     done_d;
  logic               cpu_rdy_q,  cpu_rdy_d;

  logic [2*WIDTH-1:0] alu_result;
  logic               alu_invalid;
  logic               mem_we;
  logic [2*WIDTH-1:0] mem_rd_q;
  logic [2*WIDTH-1:0] mem [MEM_DEPTH];

  assign {cmd_mode, cmd_sel_b, cmd_sel_a, cmd_op} = cmd_in;

  // Out-of-range selects fall through to channel 0 and are flagged separately
  always_comb begin
    chan_a = din[WIDTH-1:0];
    chan_b = din[WIDTH-1:0];
    for (int k = 1; k < N_IN; k++) begin
      if (cmd_sel_a == SEL_W'(k)) chan_a = din[k*WIDTH +: WIDTH];
      if (cmd_sel_b == SEL_W'(k)) chan_b = din[k*WIDTH +: WIDTH];
    end
    sel_bad = ({1'b0, cmd_sel_a} >= N_IN_EXT) || ({1'b0, cmd_sel_b} >= N_IN_EXT);
  end

  cpu_alu_param #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a       (op_a_q),
    .b       (op_b_q),
    .op      (op_q),
    .result  (alu_result),
    .invalid (alu_invalid)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    addr_d     = addr_q;
    sel_bad_d  = sel_bad_q;
    out_reg3_d = out_reg3_q;
    zero_d     = zero_q;
    error_d    = error_q;
    done_d     = 1'b0;
    mem_we     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cpu_rdy_q) begin
          op_d      = cmd_op;
          op_a_d    = chan_a;
          op_b_d    = chan_b;
          addr_d    = chan_a[ADDR_W-1:0];
          sel_bad_d = sel_bad;
          case (mode_e'(cmd_mode))
            MODE_ALU:   state_d = ST_EXEC;
            MODE_STORE: state_d = ST_MEMWR;
            MODE_LOAD:  state_d = ST_MEMRD;
            default: begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              error_d = 1'b1;
            end
          endcase
        end
      end
      ST_EXEC: begin
        out_reg3_d = alu_result;
        zero_d     = (alu_result == '0) && !alu_invalid;
        error_d    = alu_invalid || sel_bad_q;
        state_d    = ST_DONE;
        done_d     = 1'b1;
      end
      ST_MEMWR: begin
        if (sel_bad_q) error_d = 1'b1;
        else           mem_we  = 1'b1;
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
      ST_MEMRD: state_d = ST_MEMWB;
      ST_MEMWB: begin
        if (sel_bad_q) begin
          error_d = 1'b1;
        end else begin
          out_reg3_d = mem_rd_q;
          zero_d     = (mem_rd_q == '0);
          error_d    = 1'b0;
        end
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    cpu_rdy_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      addr_q     <= '0;
      sel_bad_q  <= 1'b0;
      out_reg3_q <= '0;
      zero_q     <= 1'b0;
      error_q    <= 1'b0;
      done_q     <= 1'b0;
      cpu_rdy_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      addr_q     <= addr_d;
      sel_bad_q  <= sel_bad_d;
      out_reg3_q <= out_reg3_d;
      zero_q     <= zero_d;
      error_q    <= error_d;
      done_q     <= done_d;
      cpu_rdy_q  <= cpu_rdy_d;
    end
  end

  // Memory is not reset; a reset during MEMWR suppresses the pending write
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[addr_q] <= out_reg3_q;
    if (state_q == ST_MEMRD) mem_rd_q <= mem[addr_q];
  end

  assign cpu_rdy  = cpu_rdy_q;
  assign done     = done_q;
  assign out_reg3 = out_reg3_q;
  assign zero     = zero_q;
  assign error    = error_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_core_param.sv
// ============================================================================
// tb_cpu_core_param : self-checking bench for cpu_core_param (default params)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cpu_core_param;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic [9:0]  cmd_in;
  logic [7:0]  ch [4];
  logic [31:0] din;
  logic        cpu_rdy;
  logic        done;
  logic [15:0] out_reg3;
  logic        zero;
  logic        error;

  assign din = {ch[3], ch[2], ch[1], ch[0]};

  cpu_core_param dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_in    (cmd_in),
    .din       (din),
    .cpu_rdy   (cpu_rdy),
    .done      (done),
    .out_reg3  (out_reg3),
    .zero      (zero),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state
  logic [15:0] exp_out;
  logic        exp_zero;
  logic        exp_err;
  logic [15:0] mem_m [256];
  bit          mem_v [256];
  int          written_q [$];

  // Observations from the last command
  int          obs_lat;
  logic [15:0] obs_out;
  logic        obs_zero, obs_err, obs_rdy_before, obs_done_after, obs_rdy_after;

  typedef struct {
    int mode; int sb; int sa; int op;
    int c0; int c1; int c2; int c3;
  } vec_t;

  function automatic int alu_ref(input int a, input int b, input int op, output bit inv);
    inv = 1'b0;
    case (op)
      0:  return a + b;
      1:  return (a - b) & 'hFFFF;
`ifdef CPU_MUL_EN
      2:  return a * b;
`endif
      3:  return a & b;
      4:  return a | b;
      5:  return a ^ b;
      6:  return 255 - a;
      7:  return a * 2;
      8:  return a / 2;
      9:  return a;
      10: return b;
      default: begin inv = 1'b1; return 0; end
    endcase
  endfunction

  // Updates the reference state; returns expected edges from accept to done
  function automatic int model_cmd(input int mode, input int sb, input int sa, input int op);
    int a, b, r;
    bit inv;
    a = int'(ch[sa]);
    b = int'(ch[sb]);
    case (mode)
      0: begin
        r = alu_ref(a, b, op, inv);
        exp_out  = 16'(r);
        exp_zero = !inv && (r == 0);
        exp_err  = inv;
        return 1;
      end
      1: begin
        mem_m[a] = exp_out;
        mem_v[a] = 1'b1;
        written_q.push_back(a);
        return 1;
      end
      2: begin
        exp_out  = mem_m[a];
        exp_zero = (mem_m[a] == 16'h0);
        exp_err  = 1'b0;
        return 2;
      end
      default: begin
        exp_err = 1'b1;
        return 0;
      end
    endcase
  endfunction

  task automatic send(input int mode, input int sb, input int sa, input int op, input bit hold);
    obs_rdy_before = cpu_rdy;
    cmd_in    = {2'(mode), 2'(sb), 2'(sa), 4'(op)};
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) begin
      cmd_valid = 1'b0;
      cmd_in    = 10'($urandom);
      for (int k = 0; k < 4; k++) ch[k] = 8'($urandom);
    end
    obs_lat = 0;
    while (done !== 1'b1 && obs_lat < 8) begin
      @(negedge clk);
      obs_lat++;
    end
    obs_out   = out_reg3;
    obs_zero  = zero;
    obs_err   = error;
    cmd_valid = 1'b0;
    @(negedge clk);
    obs_done_after = done;
    obs_rdy_after  = cpu_rdy;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_in = '0;
    for (int k = 0; k < 4; k++) ch[k] = 8'h00;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({cpu_rdy, done, out_reg3, zero, error} !== 20'h0) begin
      failures++;
      $display("FAIL reset_state got rdy=%b done=%b out=%h zero=%b err=%b want all zero",
               cpu_rdy, done, out_reg3, zero, error);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (cpu_rdy !== 1'b1 || done !== 1'b0 || out_reg3 !== 16'h0) begin
      failures++;
      $display("FAIL reset_idle got rdy=%b done=%b out=%h want rdy=1 done=0 out=0000",
               cpu_rdy, done, out_reg3);
    end
    exp_out = 16'h0; exp_zero = 1'b0; exp_err = 1'b0;
  endtask

  task automatic test_directed();
    vec_t tv [12];
    int   elat;
    tv = '{
      '{0, 3, 2, 0,  'h00, 'h00, 'hFF, 'h01},   // ADD carry -> 0100
      '{0, 1, 0, 1,  'h5A, 'h5A, 'h00, 'h00},   // SUB to zero
      '{0, 1, 0, 2,  'hFF, 'hFF, 'h00, 'h00},   // MUL or invalid
      '{0, 1, 0, 12, 'h33, 'h44, 'h00, 'h00},   // reserved op
      '{0, 0, 0, 7,  'h81, 'h00, 'h00, 'h00},   // SHL carry -> 0102
      '{3, 0, 0, 0,  'h11, 'h22, 'h33, 'h44},   // reserved mode
      '{0, 1, 0, 1,  'h01, 'h02, 'h00, 'h00},   // SUB wrap -> FFFF
      '{0, 0, 0, 6,  'h0F, 'h00, 'h00, 'h00},   // NOT_A -> 00F0
      '{0, 1, 0, 0,  'hFF, 'h24, 'h00, 'h00},   // ADD -> 0123
      '{1, 0, 0, 0,  'h10, 'h00, 'h00, 'h00},   // STORE @10
      '{0, 0, 0, 9,  'h10, 'h00, 'h00, 'h00},   // PASS_A -> 0010
      '{2, 0, 0, 0,  'h10, 'h00, 'h00, 'h00}    // LOAD @10 -> 0123
    };
    for (int i = 0; i < 12; i++) begin
      ch[0] = 8'(tv[i].c0); ch[1] = 8'(tv[i].c1);
      ch[2] = 8'(tv[i].c2); ch[3] = 8'(tv[i].c3);
      elat = model_cmd(tv[i].mode, tv[i].sb, tv[i].sa, tv[i].op);
      send(tv[i].mode, tv[i].sb, tv[i].sa, tv[i].op, 1'b0);
      checks++;
      if (obs_lat != elat) begin
        failures++;
        $display("FAIL directed[%0d] latency got %0d want %0d", i, obs_lat, elat);
      end
      checks++;
      if (obs_out !== exp_out || obs_zero !== exp_zero || obs_err !== exp_err) begin
        failures++;
        $display("FAIL directed[%0d] result got out=%h zero=%b err=%b want out=%h zero=%b err=%b",
                 i, obs_out, obs_zero, obs_err, exp_out, exp_zero, exp_err);
      end
      checks++;
      if (obs_rdy_before !== 1'b1 || obs_done_after !== 1'b0 || obs_rdy_after !== 1'b1) begin
        failures++;
        $display("FAIL directed[%0d] handshake got rdy_before=%b done_after=%b rdy_after=%b want 1 0 1",
                 i, obs_rdy_before, obs_done_after, obs_rdy_after);
      end
    end
  endtask

  task automatic test_back_to_back();
    int elat;
    int pulses;
    for (int i = 0; i < 2; i++) begin
      ch[0] = 8'(8'h30 + i); ch[1] = 8'h05; ch[2] = 8'h00; ch[3] = 8'h00;
      elat = model_cmd(0, 1, 0, 0);
      send(0, 1, 0, 0, 1'b1);
      checks++;
      if (obs_lat != elat || obs_out !== exp_out || obs_err !== exp_err) begin
        failures++;
        $display("FAIL b2b[%0d] held_valid got lat=%0d out=%h err=%b want lat=%0d out=%h err=%b",
                 i, obs_lat, obs_out, obs_err, elat, exp_out, exp_err);
      end
      pulses = 0;
      for (int c = 0; c < 4; c++) begin
        if (done === 1'b1) pulses++;
        @(negedge clk);
      end
      checks++;
      if (pulses != 0 || obs_done_after !== 1'b0) begin
        failures++;
        $display("FAIL b2b[%0d] extra_done got %0d extra pulses want 0", i, pulses);
      end
    end
  endtask

  task automatic test_reset_mid_store();
    int elat;
    // Establish mem[0x20] = 0x0077, then leave out_reg3 = 0x0099
    ch[0] = 8'h00; ch[1] = 8'h77;
    elat = model_cmd(0, 1, 0, 10); send(0, 1, 0, 10, 1'b0);
    ch[0] = 8'h20;
    elat = model_cmd(1, 0, 0, 0);  send(1, 0, 0, 0, 1'b0);
    ch[0] = 8'h00; ch[1] = 8'h99;
    elat = model_cmd(0, 1, 0, 10); send(0, 1, 0, 10, 1'b0);
    checks++;
    if (obs_out !== 16'h0099) begin
      failures++;
      $display("FAIL rst_store setup got out=%h want 0099", obs_out);
    end
    ch[0] = 8'h20;
    cmd_in = {2'd1, 2'd0, 2'd0, 4'd0};
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || cpu_rdy !== 1'b0 || out_reg3 !== 16'h0 || error !== 1'b0) begin
      failures++;
      $display("FAIL rst_store abort got done=%b rdy=%b out=%h err=%b want 0 0 0000 0",
               done, cpu_rdy, out_reg3, error);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (cpu_rdy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL rst_store idle got rdy=%b done=%b want 1 0", cpu_rdy, done);
    end
    exp_out = 16'h0; exp_zero = 1'b0; exp_err = 1'b0;
    ch[0] = 8'h20;
    elat = model_cmd(2, 0, 0, 0);
    send(2, 0, 0, 0, 1'b0);
    checks++;
    if (obs_out !== exp_out || obs_lat != elat || obs_err !== 1'b0) begin
      failures++;
      $display("FAIL rst_store no_write got out=%h lat=%0d err=%b want out=%h lat=%0d err=0",
               obs_out, obs_lat, obs_err, exp_out, elat);
    end
  endtask

  task automatic test_random();
    int mode, sb, sa, op, elat, pick;
    for (int i = 0; i < 60; i++) begin
      for (int k = 0; k < 4; k++) ch[k] = 8'($urandom);
      mode = $urandom_range(0, 9);
      mode = (mode < 5) ? 0 : (mode < 7) ? 1 : (mode < 9) ? 2 : 3;
      sb = $urandom_range(0, 3);
      sa = $urandom_range(0, 3);
      op = $urandom_range(0, 15);
      if (mode == 2) begin
        pick = written_q[$urandom_range(0, written_q.size() - 1)];
        ch[sa] = 8'(pick);
      end
      elat = model_cmd(mode, sb, sa, op);
      send(mode, sb, sa, op, 1'b0);
      checks++;
      if (obs_lat != elat || obs_out !== exp_out || obs_zero !== exp_zero || obs_err !== exp_err) begin
        failures++;
        $display("FAIL random[%0d] mode=%0d op=%0d got lat=%0d out=%h zero=%b err=%b want lat=%0d out=%h zero=%b err=%b",
                 i, mode, op, obs_lat, obs_out, obs_zero, obs_err, elat, exp_out, exp_zero, exp_err);
      end
      checks++;
      if (obs_done_after !== 1'b0 || obs_rdy_after !== 1'b1) begin
        failures++;
        $display("FAIL random[%0d] handshake got done_after=%b rdy_after=%b want 0 1",
                 i, obs_done_after, obs_rdy_after);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_store();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
